// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the alu_seq instruction sequencer:
//                op-code encoding, FSM state encoding, instruction field
//                offsets and small helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 32;

  // ALU operation codes as carried in the instruction op field.
  typedef enum logic [2:0] {
    OP_PASS2 = 3'd0,  // result = in2
    OP_PASS1 = 3'd1,  // result = in1
    OP_ADD   = 3'd2,  // result = in1 + in2, wraps mod 2^32
    OP_MUL   = 3'd3,  // signed 16x16 product of the low halves
    OP_EQ    = 3'd4,  // result = (in1 == in2)
    OP_LT    = 3'd5,  // result = (in1 < in2), signed
    OP_NOT   = 3'd6,  // result = ~in2
    OP_ILL   = 3'd7   // illegal: sequenced but never written back
  } op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  // Instruction layout, MSB first: {op, rd, rs1, rs2}. Offsets are the LSB
  // position of each field for a given register address width.
  function automatic int op_lsb(input int aw);
    return 3 * aw;
  endfunction

  function automatic int rd_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int rs1_lsb(input int aw);
    return aw;
  endfunction

  function automatic int rs2_lsb(input int aw);
    return 0 * aw;
  endfunction

  function automatic logic op_legal(input op_e op);
    return (op != OP_ILL);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_rf.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_rf
//  Description : Register file for alu_seq. One synchronous write port,
//                three combinational read ports (rs1, rs2, debug). A
//                synchronous reset clears every entry.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                we/waddr/wdata      - write port
//                raddr1/rdata1       - read port 1 (rs1)
//                raddr2/rdata2       - read port 2 (rs2)
//                raddr3/rdata3       - read port 3 (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_rf
  import alu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     raddr3,
  output logic [DATA_W-1:0] rdata3
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata1 = r_mem[raddr1];
  assign rdata2 = r_mem[raddr2];
  assign rdata3 = r_mem[raddr3];

endmodule : alu_seq_rf
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Three-state instruction sequencer (IDLE -> ISSUE -> WB) in
//                front of an external combinational ALU. An accepted
//                instruction captures its operands, drives the ALU for two
//                cycles and writes the result back to the register file at
//                the end of WB, pulsing res_valid during WB.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                instr_valid/instr_ready     - instruction handshake
//                instr                       - {op, rd, rs1, rs2}, MSB first
//                wr_en/wr_addr/wr_data       - external preload (IDLE only)
//                alu_op/alu_in1/alu_in2      - to external ALU
//                alu_out                     - from external ALU
//                res_valid/res_addr/res_data - writeback strobe
//                dbg_addr/dbg_data           - combinational register read
//                err                         - illegal-op pulse (optional)
//  Config      : define ALU_SEQ_ERR_EN to add the err output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OP_W+3*AW-1:0]     instr,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [OP_W-1:0]          alu_op,
  output logic signed [DATA_W-1:0] alu_in1,
  output logic signed [DATA_W-1:0] alu_in2,
  input  logic signed [DATA_W-1:0] alu_out,
  output logic                     res_valid,
  output logic [AW-1:0]            res_addr,
  output logic [DATA_W-1:0]        res_data,
  input  logic [AW-1:0]            dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
`ifdef ALU_SEQ_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int C_OP_LSB  = op_lsb(AW);
  localparam int C_RD_LSB  = rd_lsb(AW);
  localparam int C_RS1_LSB = rs1_lsb(AW);
  localparam int C_RS2_LSB = rs2_lsb(AW);

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  op_e           w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_rs1;
  logic [AW-1:0] w_rs2;

  assign w_op  = op_e'(instr[C_OP_LSB +: OP_W]);
  assign w_rd  = instr[C_RD_LSB  +: AW];
  assign w_rs1 = instr[C_RS1_LSB +: AW];
  assign w_rs2 = instr[C_RS2_LSB +: AW];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e                   r_state;
  state_e                   w_state_next;
  op_e                      r_op;
  logic [AW-1:0]            r_rd;
  logic signed [DATA_W-1:0] r_in1;
  logic signed [DATA_W-1:0] r_in2;
  logic                     r_res_valid;
  logic [AW-1:0]            r_res_addr;
  logic [DATA_W-1:0]        r_res_data;

  logic                     w_accept;
  logic                     w_host_wr;
  logic                     w_op_legal;

  assign w_accept   = instr_valid && instr_ready;
  // External writes are only honoured while idle; in ISSUE/WB they are lost.
  assign w_host_wr  = wr_en && (r_state == ST_IDLE);
  assign w_op_legal = op_legal(r_op);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic              w_rf_we;
  logic [AW-1:0]     w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic [DATA_W-1:0] w_rf_rs1;
  logic [DATA_W-1:0] w_rf_rs2;

  // The writeback and a host write never collide: one needs WB, the other
  // IDLE. The writeback value was sampled from alu_out at the end of ISSUE;
  // the ALU inputs are held, so it equals alu_out during WB.
  assign w_rf_we    = (r_state == ST_WB && r_res_valid) || w_host_wr;
  assign w_rf_waddr = (r_state == ST_WB) ? r_res_addr : wr_addr;
  assign w_rf_wdata = (r_state == ST_WB) ? r_res_data : wr_data;

  alu_seq_rf #(
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (w_rf_we),
    .waddr  (w_rf_waddr),
    .wdata  (w_rf_wdata),
    .raddr1 (w_rs1),
    .rdata1 (w_rf_rs1),
    .raddr2 (w_rs2),
    .rdata2 (w_rf_rs2),
    .raddr3 (dbg_addr),
    .rdata3 (dbg_data)
  );

  // A host write landing in the accept cycle is not yet in the array, so
  // forward it into the operand capture.
  logic [DATA_W-1:0] w_opnd1;
  logic [DATA_W-1:0] w_opnd2;

  assign w_opnd1 = (w_host_wr && wr_addr == w_rs1) ? wr_data : w_rf_rs1;
  assign w_opnd2 = (w_host_wr && wr_addr == w_rs2) ? wr_data : w_rf_rs2;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and ALU-facing outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    alu_op       = '0;
    alu_in1      = '0;
    alu_in2      = '0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WB: begin
        // An illegal op is hidden from the ALU as op 0.
        alu_op       = w_op_legal ? r_op : OP_PASS2;
        alu_in1      = r_in1;
        alu_in2      = r_in2;
        w_state_next = (r_state == ST_ISSUE) ? ST_WB : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand capture and writeback registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_PASS2;
      r_rd        <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_res_data  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op;
        r_rd  <= w_rd;
        r_in1 <= w_opnd1;
        r_in2 <= w_opnd2;
      end
      // res_* become visible exactly during WB.
      r_res_valid <= (r_state == ST_ISSUE) && w_op_legal;
      if (r_state == ST_ISSUE && w_op_legal) begin
        r_res_addr <= r_rd;
        r_res_data <= alu_out;
      end
    end
  end

  // Reset in WB abandons the instruction, so the strobe is masked too.
  assign res_valid = r_res_valid && !rst;
  assign res_addr  = r_res_addr;
  assign res_data  = r_res_data;

`ifdef ALU_SEQ_ERR_EN
  // --------------------------------------------------------------------------
  // Illegal-op indication, aligned with the WB cycle
  // --------------------------------------------------------------------------
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_ISSUE) && !w_op_legal;
    end
  end

  assign err = r_err && !rst;
`endif

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq. Supplies a
//                behavioural ALU, keeps a reference register file and a
//                scoreboard of expected writebacks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                instr_valid;
  logic                instr_ready;
  logic [3+3*AW-1:0]   instr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [31:0]         wr_data;
  logic [2:0]          alu_op;
  logic signed [31:0]  alu_in1;
  logic signed [31:0]  alu_in2;
  logic signed [31:0]  alu_out;
  logic                res_valid;
  logic [AW-1:0]       res_addr;
  logic [31:0]         res_data;
  logic [AW-1:0]       dbg_addr;
  logic [31:0]         dbg_data;
`ifdef ALU_SEQ_ERR_EN
  logic                err;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_rf [NREG];

  alu_seq #(.NREG(NREG)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef ALU_SEQ_ERR_EN
    ,
    .err         (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour.
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [31:0] p;
    x = a[15:0];
    y = b[15:0];
    p = x * y;
    case (op)
      3'd0:    return b;
      3'd1:    return a;
      3'd2:    return a + b;
      3'd3:    return p;
      3'd4:    return {31'd0, a == b};
      3'd5:    return {31'd0, $signed(a) < $signed(b)};
      3'd6:    return ~b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_op, alu_in1, alu_in2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input int a, input logic [31:0] exp, input string tag);
    dbg_addr = a[AW-1:0];
    #1;
    chk(tag, dbg_data, exp);
    tick();
  endtask

  task automatic dbg_all(input string tag);
    for (int i = 0; i < NREG; i++) dbg_chk(i, model_rf[i], tag);
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
    model_rf[a] = d;
  endtask

  // One instruction, with optional same-cycle host write (forwarding) and
  // optional host write attempted during ISSUE (must be dropped).
  task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                       input bit fwd = 1'b0, input int fa = 0, input logic [31:0] fd = 32'd0,
                       input bit drop = 1'b0);
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   r;
    logic [AW-1:0] rdv;
    logic [AW-1:0] r1v;
    logic [AW-1:0] r2v;
    bit            legal;
    legal = (op != 3'd7);
    rdv = rd[AW-1:0];
    r1v = rs1[AW-1:0];
    r2v = rs2[AW-1:0];
    instr       = {op, rdv, r1v, r2v};
    instr_valid = 1'b1;
    if (fwd) begin
      wr_en       = 1'b1;
      wr_addr     = fa[AW-1:0];
      wr_data     = fd;
      model_rf[fa] = fd;
    end
    a = model_rf[rs1];
    b = model_rf[rs2];
    r = alu_f(op, a, b);
    @(negedge clk);
    chk("accept_ready", instr_ready, 32'd1);
    tick();                                   // accept edge (N)
    instr_valid = 1'b0;
    wr_en       = 1'b0;
    if (legal) begin
      sb.push_back('{rdv, r});
      model_rf[rd] = r;
    end
    if (drop) begin
      wr_en   = 1'b1;
      wr_addr = rdv;
      wr_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);                           // ISSUE (N+1)
    chk("issue_alu_op", alu_op, legal ? op : 3'd0);
    chk("issue_in1", alu_in1, a);
    chk("issue_in2", alu_in2, b);
    chk("issue_ready", instr_ready, 32'd0);
    chk("issue_res_valid", res_valid, 32'd0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);                           // WB (N+2)
    chk("wb_res_valid", res_valid, {31'd0, legal});
    chk("wb_alu_in1", alu_in1, a);
`ifdef ALU_SEQ_ERR_EN
    chk("wb_err", err, {31'd0, !legal});
`endif
    tick();                                   // back in IDLE (N+3)
  endtask

  // Scoreboard consumer: every writeback strobe must match the oldest entry.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed res_valid=1 expected=no writeback");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("res_addr", {29'd0, res_addr}, {29'd0, mon_e.addr});
        chk("res_data", res_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  logic [2:0]    p_op [3];
  logic [AW-1:0] p_rd [3];
  logic [AW-1:0] p_r1 [3];
  logic [AW-1:0] p_r2 [3];
  logic [31:0]   ba;
  logic [31:0]   bb;
  logic [31:0]   br;
  int            k;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    for (int i = 0; i < NREG; i++) model_rf[i] = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", instr_ready, 32'd1);
    chk("rst_res_valid", res_valid, 32'd0);
    chk("rst_res_addr", {29'd0, res_addr}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_alu_op", alu_op, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
`ifdef ALU_SEQ_ERR_EN
    chk("rst_err", err, 32'd0);
`endif
    tick();
    dbg_all("rst_rf");

    // Add: 5 + -3 = 2
    preload(1, 32'd5);
    preload(2, -32'sd3);
    issue(3'd2, 3, 1, 2);
    dbg_chk(3, 32'd2, "add_r3");

    // Multiply low halves: -32768 * 2
    preload(1, 32'h0001_8000);
    preload(2, 32'h0000_0002);
    issue(3'd3, 4, 1, 2);
    dbg_chk(4, 32'hFFFF_0000, "mul_r4");

    // Compare and NOT
    preload(1, 32'hFFFF_FFFF);
    preload(2, 32'd1);
    issue(3'd5, 5, 1, 2);
    dbg_chk(5, 32'd1, "lt_r5");
    preload(1, 32'd7);
    preload(2, 32'd7);
    issue(3'd4, 6, 1, 2);
    dbg_chk(6, 32'd1, "eq_r6");
    preload(2, 32'd0);
    issue(3'd6, 7, 1, 2);
    dbg_chk(7, 32'hFFFF_FFFF, "not_r7");

    // Pass ops, including a write to r0
    issue(3'd0, 0, 1, 6);
    dbg_chk(0, 32'd1, "pass2_r0");
    issue(3'd1, 2, 1, 0);
    dbg_chk(2, 32'd7, "pass1_r2");

    // rd = rs1 = rs2: 1+1, then 2+2 from the freshly written value
    issue(3'd2, 5, 5, 5);
    issue(3'd2, 5, 5, 5);
    dbg_chk(5, 32'd4, "self_dep_r5");

    // Same-cycle host write to r1 forwarded into capture: 100 + 100
    issue(3'd2, 2, 1, 1, 1'b1, 1, 32'd100);
    dbg_chk(2, 32'd200, "fwd_r2");

    // instr_valid held high across three dependent instructions
    p_op[0] = 3'd2; p_rd[0] = 3'd3; p_r1[0] = 3'd1; p_r2[0] = 3'd1;  // r3 = 200
    p_op[1] = 3'd2; p_rd[1] = 3'd4; p_r1[1] = 3'd3; p_r2[1] = 3'd1;  // r4 = 300
    p_op[2] = 3'd1; p_rd[2] = 3'd5; p_r1[2] = 3'd4; p_r2[2] = 3'd0;  // r5 = 300
    instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      k = c / 3;
      instr = {p_op[k], p_rd[k], p_r1[k], p_r2[k]};
      if (c % 3 == 0) begin
        ba = model_rf[p_r1[k]];
        bb = model_rf[p_r2[k]];
        br = alu_f(p_op[k], ba, bb);
        sb.push_back('{p_rd[k], br});
        model_rf[p_rd[k]] = br;
      end
      @(negedge clk);
      chk("b2b_ready", instr_ready, (c % 3 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    instr_valid = 1'b0;
    dbg_chk(3, 32'd200, "b2b_r3");
    dbg_chk(5, 32'd300, "b2b_r5");

    // Illegal op with a host write attempted during ISSUE
    issue(3'd7, 4, 1, 2, 1'b0, 0, 32'd0, 1'b1);
    dbg_chk(4, 32'd300, "ill_r4_kept");
    dbg_all("ill_rf");

    // Reset one cycle after accept abandons the instruction
    instr = {3'd2, 3'd6, 3'd5, 3'd5};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_alu_op", alu_op, 32'd2);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) model_rf[i] = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_mid_res_valid", res_valid, 32'd0);
      chk("rst_mid_ready", instr_ready, 32'd1);
      tick();
    end
    dbg_all("rst_mid_rf");

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_seq
`default_nettype wire
